// File: rtl/bcd_grant_lock_decoder_pkg.sv
// Shared definitions for the grant-lock decoder that sits between the
// switch-allocator arbiter and the crossbar mux of one router output port.
//   - state_t   : two-state lock FSM encoding (IDLE / LOCKED)
//   - width_for : log2 helper for port and counter widths (never returns 0)
package bcd_grant_lock_decoder_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int DEF_IN_WIDTH = 4;
  localparam int DEF_MAX_IDLE = 15;

  // Number of bits needed to encode n distinct values. A single value
  // still gets one bit so that no vector ends up zero-width.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_to_onehot.sv
// Binary (BCD) to one-hot decoder.
// Ports:
//   bcd    : in,  SEL_WIDTH  binary index
//   onehot : out, IN_WIDTH   one-hot decode; all zeros when bcd >= IN_WIDTH
// Purely combinational.
module bcd_to_onehot #(
  parameter int IN_WIDTH  = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [SEL_WIDTH-1:0] bcd,
  output logic [IN_WIDTH-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      onehot[i] = (bcd == SEL_WIDTH'(i));
    end
  end

endmodule

// File: rtl/bcd_grant_lock_decoder.sv
// Consumer side of the fixed-priority BCD arbiter. Captures the binary grant,
// registers a one-hot crossbar select and holds it for a whole packet (head
// flit through tail flit). Releases on the tail transfer or on an idle
// timeout.
// Ports:
//   clk          : in,  rising-edge clock
//   reset        : in,  asynchronous active-high reset
//   request      : in,  IN_WIDTH  per-port request (same vector the arbiter sees)
//   grant_bcd    : in,  SEL_WIDTH binary grant from the arbiter
//   any_grant    : in,  arbiter valid
//   valid_in     : in,  IN_WIDTH  per-port flit valid
//   tail_in      : in,  IN_WIDTH  per-port tail marker, qualified by valid_in
//   out_ready    : in,  downstream credit available this cycle
//   grant_onehot : out, IN_WIDTH  registered one-hot crossbar select
//   sel_bcd      : out, SEL_WIDTH registered binary copy of the locked port
//   locked       : out, high while the FSM is in LOCKED (direct view of state)
//   ack          : out, IN_WIDTH  one-cycle pulse to the newly locked port
//   xfer         : out, combinational: a flit moves this cycle
//   timeout      : out, one-cycle pulse on forced (idle) release
//
// Handshake: a flit moves in a cycle exactly when the FSM is LOCKED, the
// locked port presents valid_in and out_ready is high (xfer). Valid never
// waits on ready; a stalled flit simply holds its valid until xfer.
module bcd_grant_lock_decoder
  import bcd_grant_lock_decoder_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int SEL_WIDTH = width_for(IN_WIDTH),
  parameter int MAX_IDLE  = DEF_MAX_IDLE,
  parameter int CNT_WIDTH = width_for(MAX_IDLE + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  request,
  input  logic [SEL_WIDTH-1:0] grant_bcd,
  input  logic                 any_grant,
  input  logic [IN_WIDTH-1:0]  valid_in,
  input  logic [IN_WIDTH-1:0]  tail_in,
  input  logic                 out_ready,
  output logic [IN_WIDTH-1:0]  grant_onehot,
  output logic [SEL_WIDTH-1:0] sel_bcd,
  output logic                 locked,
  output logic [IN_WIDTH-1:0]  ack,
  output logic                 xfer,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT    = CNT_WIDTH'(MAX_IDLE);
  localparam bit                   TIMEOUT_EN = (MAX_IDLE > 0);

  state_t                state, state_next;
  logic [IN_WIDTH-1:0]   grant_dec;
  logic [IN_WIDTH-1:0]   onehot_next, ack_next;
  logic [SEL_WIDTH-1:0]  sel_next;
  logic [CNT_WIDTH-1:0]  idle_cnt, idle_cnt_next;
  logic                  timeout_next;
  logic                  lock_hit, tail_hit, idle_expired;

  // One decoder shared by the select and ack registers.
  bcd_to_onehot #(
    .IN_WIDTH (IN_WIDTH),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_dec (
    .bcd   (grant_bcd),
    .onehot(grant_dec)
  );

  // An out-of-range grant decodes to zero, so it can never match a request;
  // an inconsistent grant (request bit low) is rejected the same way.
  assign lock_hit = any_grant & (|(request & grant_dec));

  // grant_onehot is zero in IDLE and equals decode(sel_bcd) in LOCKED, so
  // masking with it selects the locked port without indexing by sel_bcd.
  assign xfer     = (state == ST_LOCKED) & out_ready & (|(valid_in & grant_onehot));
  assign tail_hit = xfer & (|(tail_in & grant_onehot));

  // A stalled flit (valid without ready) counts as idle as well.
  assign idle_expired = TIMEOUT_EN && (idle_cnt == MAX_CNT) && !xfer;

  assign locked = (state == ST_LOCKED);

  always_comb begin
    state_next    = state;
    onehot_next   = grant_onehot;
    sel_next      = sel_bcd;
    ack_next      = '0;
    timeout_next  = 1'b0;
    idle_cnt_next = idle_cnt;

    case (state)
      ST_IDLE: begin
        onehot_next   = '0;
        idle_cnt_next = '0;
        if (lock_hit) begin
          state_next  = ST_LOCKED;
          onehot_next = grant_dec;
          sel_next    = grant_bcd;
          ack_next    = grant_dec;
        end
      end

      ST_LOCKED: begin
        // Arbiter inputs are deliberately ignored here.
        if (xfer) begin
          idle_cnt_next = '0;
        end else if (idle_cnt != MAX_CNT) begin
          idle_cnt_next = idle_cnt + CNT_WIDTH'(1);
        end

        // The tail takes priority: a tail transfer is never idle, so a
        // coincident timeout cannot fire.
        if (tail_hit) begin
          state_next    = ST_IDLE;
          onehot_next   = '0;
          idle_cnt_next = '0;
        end else if (idle_expired) begin
          state_next    = ST_IDLE;
          onehot_next   = '0;
          idle_cnt_next = '0;
          timeout_next  = 1'b1;
        end
      end

      default: begin
        state_next  = ST_IDLE;
        onehot_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      grant_onehot <= '0;
      sel_bcd      <= '0;
      ack          <= '0;
      timeout      <= 1'b0;
      idle_cnt     <= '0;
    end else begin
      state        <= state_next;
      grant_onehot <= onehot_next;
      sel_bcd      <= sel_next;
      ack          <= ack_next;
      timeout      <= timeout_next;
      idle_cnt     <= idle_cnt_next;
    end
  end

endmodule

// File: tb/tb_bcd_grant_lock_decoder.sv
// Bench for bcd_grant_lock_decoder (IN_WIDTH=4, MAX_IDLE=15).
module tb_bcd_grant_lock_decoder;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] request;
  logic [1:0] grant_bcd;
  logic       any_grant;
  logic [3:0] valid_in;
  logic [3:0] tail_in;
  logic       out_ready;
  logic [3:0] grant_onehot;
  logic [1:0] sel_bcd;
  logic       locked;
  logic [3:0] ack;
  logic       xfer;
  logic       timeout;

  always #5 clk = ~clk;

  bcd_grant_lock_decoder #(
    .IN_WIDTH(4),
    .MAX_IDLE(15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
    .grant_bcd   (grant_bcd),
    .any_grant   (any_grant),
    .valid_in    (valid_in),
    .tail_in     (tail_in),
    .out_ready   (out_ready),
    .grant_onehot(grant_onehot),
    .sel_bcd     (sel_bcd),
    .locked      (locked),
    .ack         (ack),
    .xfer        (xfer),
    .timeout     (timeout)
  );

  // ---------------- counters / scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every ack pulse must match the next expected grant, in order.
  always @(negedge clk) begin
    if (!reset && ack != 4'b0000) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL ack_scoreboard: got unexpected ack %b", ack);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (ack !== e) begin
          n_bad++;
          $display("FAIL ack_scoreboard: got %b expected %b", ack, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] req, input logic [1:0] g, input logic ag,
                       input logic [3:0] v, input logic [3:0] t, input logic rdy);
    request   = req;
    grant_bcd = g;
    any_grant = ag;
    valid_in  = v;
    tail_in   = t;
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant port p for one cycle; returns in the first LOCKED cycle (edge+2).
  task automatic lock_port(input int p);
    logic [3:0] oh;
    oh = 4'b0001 << p;
    drive(oh, 2'(p), 1'b1, 4'b0000, 4'b0000, 1'b0);
    step();
    exp_q.push_back(oh);
    drive(4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    #1;
    check("lock_locked", locked, 1);
    check("lock_onehot", grant_onehot, oh);
    check("lock_ack", ack, oh);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] request;
    logic [1:0] grant_bcd;
    logic       any_grant;
    logic [3:0] valid_in;
    logic [3:0] tail_in;
    logic       out_ready;
    logic [3:0] exp_onehot;
    logic [1:0] exp_sel;
    logic       exp_locked;
    logic [3:0] exp_ack;
    logic       exp_xfer;
    logic       exp_timeout;
  } vec_t;

  localparam int NV = 20;
  vec_t vec[NV];

  initial begin
    // inputs applied this cycle | outputs expected in this same cycle
    vec[0]  = '{4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0,  4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    // inconsistent grant: port 3 granted but only port 0 requests
    vec[1]  = '{4'b0001, 2'd3, 1'b1, 4'b0000, 4'b0000, 1'b0,  4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vec[2]  = '{4'b0001, 2'd3, 1'b1, 4'b0000, 4'b0000, 1'b0,  4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    // lock port 1, then a 3-flit packet
    vec[3]  = '{4'b1010, 2'd1, 1'b1, 4'b0000, 4'b0000, 1'b0,  4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vec[4]  = '{4'b1010, 2'd1, 1'b0, 4'b0010, 4'b0000, 1'b1,  4'b0010, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0};
    vec[5]  = '{4'b1010, 2'd1, 1'b0, 4'b0011, 4'b0000, 1'b1,  4'b0010, 2'd1, 1'b1, 4'b0000, 1'b1, 1'b0};
    vec[6]  = '{4'b1010, 2'd1, 1'b0, 4'b0010, 4'b0010, 1'b1,  4'b0010, 2'd1, 1'b1, 4'b0000, 1'b1, 1'b0};
    vec[7]  = '{4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0,  4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0};
    // single-flit packet on port 3, arbiter keeps granting port 3
    vec[8]  = '{4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000, 1'b0,  4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0};
    vec[9]  = '{4'b1000, 2'd3, 1'b1, 4'b1000, 4'b1000, 1'b1,  4'b1000, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0};
    vec[10] = '{4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000, 1'b0,  4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0};
    vec[11] = '{4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000, 1'b0,  4'b1000, 2'd3, 1'b1, 4'b1000, 1'b0, 1'b0};
    vec[12] = '{4'b0000, 2'd0, 1'b0, 4'b1000, 4'b1000, 1'b1,  4'b1000, 2'd3, 1'b1, 4'b0000, 1'b1, 1'b0};
    vec[13] = '{4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0,  4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0};
    // lock port 2; arbiter switches to port 0 (ignored); stalls; foreign flit
    vec[14] = '{4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0000, 1'b0,  4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0};
    vec[15] = '{4'b0101, 2'd0, 1'b1, 4'b0100, 4'b0000, 1'b0,  4'b0100, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0};
    vec[16] = '{4'b0101, 2'd0, 1'b1, 4'b0001, 4'b0001, 1'b1,  4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b0};
    vec[17] = '{4'b0101, 2'd0, 1'b1, 4'b0100, 4'b0000, 1'b0,  4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b0};
    vec[18] = '{4'b0101, 2'd0, 1'b1, 4'b0100, 4'b0100, 1'b1,  4'b0100, 2'd2, 1'b1, 4'b0000, 1'b1, 1'b0};
    vec[19] = '{4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0,  4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
  end

  // ---------------- test ----------------
  initial begin
    reset = 1'b1;
    drive(4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_onehot", grant_onehot, 4'b0000);
    check("rst_locked", locked, 0);
    check("rst_ack", ack, 4'b0000);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;

    // table-driven vectors: one row per clock cycle
    for (int i = 0; i < NV; i++) begin
      drive(vec[i].request, vec[i].grant_bcd, vec[i].any_grant,
            vec[i].valid_in, vec[i].tail_in, vec[i].out_ready);
      if (vec[i].exp_ack != 4'b0000) exp_q.push_back(vec[i].exp_ack);
      #1;
      check($sformatf("v%0d_onehot", i), grant_onehot, vec[i].exp_onehot);
      check($sformatf("v%0d_sel", i), sel_bcd, vec[i].exp_sel);
      check($sformatf("v%0d_locked", i), locked, vec[i].exp_locked);
      check($sformatf("v%0d_ack", i), ack, vec[i].exp_ack);
      check($sformatf("v%0d_xfer", i), xfer, vec[i].exp_xfer);
      check($sformatf("v%0d_timeout", i), timeout, vec[i].exp_timeout);
      step();
    end

    // idle timeout: 16 LOCKED cycles without a flit
    lock_port(0);
    for (int k = 1; k <= 16; k++) begin
      check("to_hold_locked", locked, 1);
      check("to_hold_pulse", timeout, 0);
      step();
    end
    #1;
    check("to_release_locked", locked, 0);
    check("to_release_pulse", timeout, 1);
    check("to_release_onehot", grant_onehot, 4'b0000);
    step();
    check("to_pulse_width", timeout, 0);

    // a flit in LOCKED cycle 10 restarts the count: release after cycle 26
    lock_port(0);
    for (int k = 1; k <= 26; k++) begin
      drive(4'b0000, 2'd0, 1'b0, (k == 10) ? 4'b0001 : 4'b0000, 4'b0000, (k == 10));
      #1;
      check("rs_xfer", xfer, (k == 10));
      check("rs_locked", locked, 1);
      check("rs_timeout", timeout, 0);
      step();
    end
    drive(4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    #1;
    check("rs_release_locked", locked, 0);
    check("rs_release_pulse", timeout, 1);
    step();

    // tail transfer in the same cycle the counter sits at MAX_IDLE
    lock_port(0);
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) drive(4'b0000, 2'd0, 1'b0, 4'b0001, 4'b0001, 1'b1);
      #1;
      check("tw_locked", locked, 1);
      check("tw_xfer", xfer, (k == 16));
      step();
    end
    drive(4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    #1;
    check("tw_release_locked", locked, 0);
    check("tw_no_timeout", timeout, 0);
    step();

    // asynchronous reset in the middle of a lock on port 2
    lock_port(2);
    check("mr_sel_before", sel_bcd, 2);
    step();
    check("mr_locked_before", locked, 1);
    #1;
    reset = 1'b1;
    #1;
    check("mr_onehot", grant_onehot, 4'b0000);
    check("mr_locked", locked, 0);
    check("mr_sel", sel_bcd, 0);
    check("mr_ack", ack, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("mr_idle_after", locked, 0);
    check("mr_onehot_after", grant_onehot, 4'b0000);

    check("ack_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
